issue_hazard_ctrl: RTL and testbench
====================================

Name: issue_hazard_ctrl

Overview:
- Issue-stage controller: the client that reads from and writes to the scoreboard.
- Latches one decoded instruction into an issue register and queries the scoreboard for its two source registers and its destination.
- Stalls on RAW, WAW and writeback-structural hazards.
- When clear, hands the instruction to the target functional unit and drives the scoreboard's synchronous claim interface (writeaddr/registerunit/enablewrite).

Parameters:
- PAYLOAD_W, 64, opaque decoded-instruction bits forwarded untouched to the functional unit.
- STALL_CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  decode offers an instruction
- id_ready  out  1  issue register can accept this cycle
- id_rs / id_rt  in  5 each  source register addresses
- id_rs_used / id_rt_used  in  1 each  source is actually read
- id_rd  in  5  destination register
- id_rd_write  in  1  instruction writes id_rd
- id_unit  in  2  unit code: 00 AluMisc, 01 Mem, 10 Mult, 11 illegal
- id_payload  in  PAYLOAD_W  decoded bits
- iss_ass_addr_a / iss_ass_addr_b  out  5 each  scoreboard lookup addresses (held rs / rt)
- iss_ass_pending_a / iss_ass_pending_b  in  1 each  scoreboard pending bit
- iss_ass_row_a / iss_ass_row_b  in  5 each  scoreboard execution-stage row
- waw_addr  out  5  scoreboard lookup for held rd
- waw_pending  in  1  pending bit for waw_addr
- waw_row  in  5  row for waw_addr
- sb_haz_column  in  32  writeback-occupancy column for registerunit
- writeaddr  out  5  register claimed this cycle
- registerunit  out  2  unit of the held instruction
- enablewrite  out  1  claim strobe
- ex_valid  out  1  instruction presented to unit
- ex_ready  in  1  unit accepts
- ex_unit  out  2  target unit
- ex_payload  out  PAYLOAD_W  forwarded payload
- flush  in  1  squash the held instruction (branch redirect)
- stall_count  out  STALL_CNT_W  saturating count of hazard-stalled cycles

Behaviour:
- State machine: EMPTY, HELD. Reset → EMPTY; all held fields, stall_count, ex_valid and enablewrite are 0.
- Lookup outputs are combinational from held fields: iss_ass_addr_a = rs, iss_ass_addr_b = rt, waw_addr = rd, registerunit = unit, ex_unit = unit, ex_payload = payload.
- Hazard terms:
  - raw_a = rs_used & rs≠0 & iss_ass_pending_a & iss_ass_row_a≠5'b00001. Row 00001 means the value is in writeback and bypassable.
  - raw_b: same form, using rt and the b lookup.
  - waw = rd_write & rd≠0 & waw_pending & (waw_row ≥ new_pos). new_pos is 00010 for AluMisc, 00100 for Mem, 10000 for Mult.
  - struct = rd_write & (sb_haz_column≠0).
  - illegal = unit==2'b11.
  - hazard = raw_a | raw_b | waw | struct | illegal.
- ex_valid = HELD & ~hazard & ~flush. fire = ex_valid & ex_ready.
- enablewrite = fire & rd_write & rd≠0. writeaddr = rd.
- id_ready = ~flush & (EMPTY | fire).
- Transitions:
  - EMPTY → HELD on id_valid & id_ready.
  - HELD → HELD on fire & id_valid (back-to-back issue, one instruction per cycle).
  - HELD → EMPTY on fire & ~id_valid.
  - Any state → EMPTY on flush; decode input is ignored that cycle, and no claim is made.
- stall_count increments when HELD & hazard & ~flush. It saturates at all-ones and does not increment on ex_ready-only stalls.
- Claim latency: enablewrite is asserted in the fire cycle; the scoreboard shows pending on the next cycle.
- Simultaneous events:
  - flush beats fire.
  - reset mid-HELD drops the instruction with no claim.
  - An illegal unit stalls until flush.

Decomposition:
- Shared package holds:
  - unit codes UNIT_AM = 2'b00, UNIT_MEM = 2'b01, UNIT_MULT = 2'b10
  - the new_pos one-hot per unit
  - the BYPASS_ROW = 5'b00001 constant
- Sub-module hazard_check: purely combinational; computes raw_a, raw_b, waw, struct and illegal from the held fields and the scoreboard responses.

Test Plan:
- Reset, then id_valid with AluMisc, rd=5, all scoreboard inputs 0, ex_ready=1 → next cycle ex_valid=1, enablewrite=1, writeaddr=5, registerunit=00.
- Held rs=3 with pending_a=1, row_a=00100 → ex_valid=0 for 2 cycles (stall_count +2); when row_a=00001 → fires.
- Held Mult rd=7 with waw_pending=1, waw_row=10000 → stalls. Held AluMisc rd=7 with waw_row=00001 → fires.
- Held Mem rd=9 with sb_haz_column=32'h0000_0100 → stall. Column 0 → fires; id_ready=1 the same cycle; a back-to-back second instruction is held the next cycle.
- flush while HELD with no hazard and ex_ready=1 → ex_valid=0, enablewrite=0, state EMPTY next cycle, id_ready=0 during flush.
- 2^STALL_CNT_W + 3 stalled cycles with an illegal unit → stall_count stays all-ones.

Source files
------------

// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared unit codes, FSM states and scoreboard row constants for the issue stage.
package issue_hazard_ctrl_pkg;

  localparam logic [1:0] UNIT_AM   = 2'b00;
  localparam logic [1:0] UNIT_MEM  = 2'b01;
  localparam logic [1:0] UNIT_MULT = 2'b10;
  localparam logic [1:0] UNIT_ILL  = 2'b11;

  localparam logic [4:0] BYPASS_ROW = 5'b00001;

  localparam logic [4:0] NEW_POS_AM   = 5'b00010;
  localparam logic [4:0] NEW_POS_MEM  = 5'b00100;
  localparam logic [4:0] NEW_POS_MULT = 5'b10000;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_e;

  // Row the new instruction's result would occupy in the execution-stage
  // shift column; the illegal code stalls anyway, so its value is moot.
  function automatic logic [4:0] new_pos(input logic [1:0] unit);
    case (unit)
      UNIT_AM:   new_pos = NEW_POS_AM;
      UNIT_MEM:  new_pos = NEW_POS_MEM;
      UNIT_MULT: new_pos = NEW_POS_MULT;
      default:   new_pos = '1;
    endcase
  endfunction

endpackage

// File: rtl/issue_hazard_ctrl_hazard_check.sv
// Combinational RAW / WAW / writeback-structural / illegal-unit hazard terms.
module hazard_check
  import issue_hazard_ctrl_pkg::*;
(
  input  logic [4:0]  rs,
  input  logic        rs_used,
  input  logic [4:0]  rt,
  input  logic        rt_used,
  input  logic [4:0]  rd,
  input  logic        rd_write,
  input  logic [1:0]  unit,
  input  logic        pending_a,
  input  logic [4:0]  row_a,
  input  logic        pending_b,
  input  logic [4:0]  row_b,
  input  logic        waw_pending,
  input  logic [4:0]  waw_row,
  input  logic [31:0] haz_column,
  output logic        raw_a,
  output logic        raw_b,
  output logic        waw,
  output logic        struct_haz,
  output logic        illegal
);

  always_comb begin
    raw_a      = rs_used & (rs != '0) & pending_a & (row_a != BYPASS_ROW);
    raw_b      = rt_used & (rt != '0) & pending_b & (row_b != BYPASS_ROW);
    // An older writer still at or behind our slot would retire after us.
    waw        = rd_write & (rd != '0) & waw_pending & (waw_row >= new_pos(unit));
    struct_haz = rd_write & (haz_column != '0);
    illegal    = (unit == UNIT_ILL);
  end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue-stage register: holds one decoded instruction, stalls on scoreboard hazards, claims rd on issue.
module issue_hazard_ctrl
  import issue_hazard_ctrl_pkg::*;
#(
  parameter int unsigned PAYLOAD_W   = 64,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic [4:0]             id_rd,
  input  logic                   id_rd_write,
  input  logic [1:0]             id_unit,
  input  logic [PAYLOAD_W-1:0]   id_payload,
  output logic [4:0]             iss_ass_addr_a,
  output logic [4:0]             iss_ass_addr_b,
  input  logic                   iss_ass_pending_a,
  input  logic                   iss_ass_pending_b,
  input  logic [4:0]             iss_ass_row_a,
  input  logic [4:0]             iss_ass_row_b,
  output logic [4:0]             waw_addr,
  input  logic                   waw_pending,
  input  logic [4:0]             waw_row,
  input  logic [31:0]            sb_haz_column,
  output logic [4:0]             writeaddr,
  output logic [1:0]             registerunit,
  output logic                   enablewrite,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic [1:0]             ex_unit,
  output logic [PAYLOAD_W-1:0]   ex_payload,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_count
);

  state_e                 state_q, state_d;
  logic [4:0]             rs_q, rs_d;
  logic [4:0]             rt_q, rt_d;
  logic                   rs_used_q, rs_used_d;
  logic                   rt_used_q, rt_used_d;
  logic [4:0]             rd_q, rd_d;
  logic                   rd_write_q, rd_write_d;
  logic [1:0]             unit_q, unit_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic raw_a, raw_b, waw, struct_haz, illegal;
  logic hazard, held, fire, load;

  hazard_check u_hazard_check (
    .rs          (rs_q),
    .rs_used     (rs_used_q),
    .rt          (rt_q),
    .rt_used     (rt_used_q),
    .rd          (rd_q),
    .rd_write    (rd_write_q),
    .unit        (unit_q),
    .pending_a   (iss_ass_pending_a),
    .row_a       (iss_ass_row_a),
    .pending_b   (iss_ass_pending_b),
    .row_b       (iss_ass_row_b),
    .waw_pending (waw_pending),
    .waw_row     (waw_row),
    .haz_column  (sb_haz_column),
    .raw_a       (raw_a),
    .raw_b       (raw_b),
    .waw         (waw),
    .struct_haz  (struct_haz),
    .illegal     (illegal)
  );

  always_comb begin
    iss_ass_addr_a = rs_q;
    iss_ass_addr_b = rt_q;
    waw_addr       = rd_q;
    writeaddr      = rd_q;
    registerunit   = unit_q;
    ex_unit        = unit_q;
    ex_payload     = payload_q;

    held        = (state_q == ST_HELD);
    hazard      = raw_a | raw_b | waw | struct_haz | illegal;
    ex_valid    = held & ~hazard & ~flush;
    fire        = ex_valid & ex_ready;
    enablewrite = fire & rd_write_q & (rd_q != '0);
    id_ready    = ~flush & (~held | fire);
    load        = id_valid & id_ready;
    stall_count = stall_q;
  end

  always_comb begin
    state_d    = state_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    rs_used_d  = rs_used_q;
    rt_used_d  = rt_used_q;
    rd_d       = rd_q;
    rd_write_d = rd_write_q;
    unit_d     = unit_q;
    payload_d  = payload_q;
    stall_d    = stall_q;

    // id_ready already folds in flush, so load never coincides with it.
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (load) begin
      state_d    = ST_HELD;
      rs_d       = id_rs;
      rt_d       = id_rt;
      rs_used_d  = id_rs_used;
      rt_used_d  = id_rt_used;
      rd_d       = id_rd;
      rd_write_d = id_rd_write;
      unit_d     = id_unit;
      payload_d  = id_payload;
    end else if (fire) begin
      state_d = ST_EMPTY;
    end

    if (held && hazard && !flush && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      rs_q       <= '0;
      rt_q       <= '0;
      rs_used_q  <= 1'b0;
      rt_used_q  <= 1'b0;
      rd_q       <= '0;
      rd_write_q <= 1'b0;
      unit_q     <= '0;
      payload_q  <= '0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      rs_used_q  <= rs_used_d;
      rt_used_q  <= rt_used_d;
      rd_q       <= rd_d;
      rd_write_q <= rd_write_d;
      unit_q     <= unit_d;
      payload_q  <= payload_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed self-checking bench for issue_hazard_ctrl.
module tb_issue_hazard_ctrl;

  localparam int unsigned PW  = 64;
  localparam int unsigned SCW = 4;

  logic           clock, reset;
  logic           id_valid, id_ready;
  logic [4:0]     id_rs, id_rt, id_rd;
  logic           id_rs_used, id_rt_used, id_rd_write;
  logic [1:0]     id_unit;
  logic [PW-1:0]  id_payload;
  logic [4:0]     iss_ass_addr_a, iss_ass_addr_b;
  logic           iss_ass_pending_a, iss_ass_pending_b;
  logic [4:0]     iss_ass_row_a, iss_ass_row_b;
  logic [4:0]     waw_addr;
  logic           waw_pending;
  logic [4:0]     waw_row;
  logic [31:0]    sb_haz_column;
  logic [4:0]     writeaddr;
  logic [1:0]     registerunit;
  logic           enablewrite, ex_valid, ex_ready;
  logic [1:0]     ex_unit;
  logic [PW-1:0]  ex_payload;
  logic           flush;
  logic [SCW-1:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  issue_hazard_ctrl #(.PAYLOAD_W(PW), .STALL_CNT_W(SCW)) dut (
    .clock             (clock),
    .reset             (reset),
    .id_valid          (id_valid),
    .id_ready          (id_ready),
    .id_rs             (id_rs),
    .id_rt             (id_rt),
    .id_rs_used        (id_rs_used),
    .id_rt_used        (id_rt_used),
    .id_rd             (id_rd),
    .id_rd_write       (id_rd_write),
    .id_unit           (id_unit),
    .id_payload        (id_payload),
    .iss_ass_addr_a    (iss_ass_addr_a),
    .iss_ass_addr_b    (iss_ass_addr_b),
    .iss_ass_pending_a (iss_ass_pending_a),
    .iss_ass_pending_b (iss_ass_pending_b),
    .iss_ass_row_a     (iss_ass_row_a),
    .iss_ass_row_b     (iss_ass_row_b),
    .waw_addr          (waw_addr),
    .waw_pending       (waw_pending),
    .waw_row           (waw_row),
    .sb_haz_column     (sb_haz_column),
    .writeaddr         (writeaddr),
    .registerunit      (registerunit),
    .enablewrite       (enablewrite),
    .ex_valid          (ex_valid),
    .ex_ready          (ex_ready),
    .ex_unit           (ex_unit),
    .ex_payload        (ex_payload),
    .flush             (flush),
    .stall_count       (stall_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0;
    id_rs_used = 0; id_rt_used = 0; id_rd_write = 0;
    id_unit = 0; id_payload = '0;
    iss_ass_pending_a = 0; iss_ass_pending_b = 0;
    iss_ass_row_a = 0; iss_ass_row_b = 0;
    waw_pending = 0; waw_row = 0; sb_haz_column = 0;
    ex_ready = 1; flush = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    #2;
    reset = 0;
    #1;
  endtask

  task automatic offer(input logic [1:0] unit, input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                       input logic rdw, input logic [PW-1:0] pl);
    id_valid = 1; id_unit = unit; id_rs = rs; id_rs_used = rsu;
    id_rt = rt; id_rt_used = rtu; id_rd = rd; id_rd_write = rdw; id_payload = pl;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    #12;
    reset = 0;
    #1;
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got %b exp 0", ex_valid); end
    n_tests++; if (enablewrite !== 1'b0) begin n_fail++; $display("FAIL reset_enablewrite got %b exp 0", enablewrite); end
    n_tests++; if (stall_count !== 4'd0) begin n_fail++; $display("FAIL reset_stall got %0d exp 0", stall_count); end
    n_tests++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL reset_id_ready got %b exp 1", id_ready); end
    n_tests++; if (writeaddr !== 5'd0 || registerunit !== 2'd0) begin n_fail++; $display("FAIL reset_fields got wa=%0d ru=%0d exp 0 0", writeaddr, registerunit); end
  endtask

  task automatic test_basic_issue();
    tick();
    offer(2'b00, 5'd0, 0, 5'd0, 0, 5'd5, 1, 64'hDEAD_BEEF_0000_0001);
    tick();
    id_valid = 0;
    #1;
    n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ex_valid got %b exp 1", ex_valid); end
    n_tests++; if (enablewrite !== 1'b1) begin n_fail++; $display("FAIL basic_enablewrite got %b exp 1", enablewrite); end
    n_tests++; if (writeaddr !== 5'd5) begin n_fail++; $display("FAIL basic_writeaddr got %0d exp 5", writeaddr); end
    n_tests++; if (registerunit !== 2'b00 || ex_unit !== 2'b00) begin n_fail++; $display("FAIL basic_unit got %b/%b exp 00", registerunit, ex_unit); end
    n_tests++; if (ex_payload !== 64'hDEAD_BEEF_0000_0001) begin n_fail++; $display("FAIL basic_payload got %h exp deadbeef00000001", ex_payload); end
    tick();
    n_tests++; if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin n_fail++; $display("FAIL basic_empty got ev=%b rdy=%b exp 0 1", ex_valid, id_ready); end
  endtask

  task automatic test_raw();
    do_reset();
    offer(2'b00, 5'd3, 1, 5'd0, 0, 5'd0, 0, 64'h1);
    iss_ass_pending_a = 1; iss_ass_row_a = 5'b00100;
    tick();
    id_valid = 0;
    #1;
    n_tests++; if (iss_ass_addr_a !== 5'd3) begin n_fail++; $display("FAIL raw_addr_a got %0d exp 3", iss_ass_addr_a); end
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall1 got %b exp 0", ex_valid); end
    tick();
    n_tests++; if (ex_valid !== 1'b0 || stall_count !== 4'd1) begin n_fail++; $display("FAIL raw_stall2 got ev=%b cnt=%0d exp 0 1", ex_valid, stall_count); end
    tick();
    n_tests++; if (stall_count !== 4'd2) begin n_fail++; $display("FAIL raw_count got %0d exp 2", stall_count); end
    iss_ass_row_a = 5'b00001;
    #1;
    n_tests++; if (ex_valid !== 1'b1 || enablewrite !== 1'b0) begin n_fail++; $display("FAIL raw_bypass got ev=%b ew=%b exp 1 0", ex_valid, enablewrite); end
    tick();
    n_tests++; if (stall_count !== 4'd2 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL raw_after got cnt=%0d ev=%b exp 2 0", stall_count, ex_valid); end
    // rt=0 with pending set is never a hazard
    offer(2'b00, 5'd0, 0, 5'd0, 1, 5'd0, 0, 64'h2);
    iss_ass_pending_a = 0; iss_ass_pending_b = 1; iss_ass_row_b = 5'b01000;
    tick();
    id_valid = 0;
    #1;
    n_tests++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL raw_r0 got %b exp 1", ex_valid); end
    tick();
    iss_ass_pending_b = 0;
  endtask

  task automatic test_waw();
    do_reset();
    offer(2'b10, 5'd0, 0, 5'd0, 0, 5'd7, 1, 64'h3);
    waw_pending = 1; waw_row = 5'b10000;
    tick();
    id_valid = 0;
    #1;
    n_tests++; if (ex_valid !== 1'b0 || waw_addr !== 5'd7) begin n_fail++; $display("FAIL waw_mult got ev=%b addr=%0d exp 0 7", ex_valid, waw_addr); end
    waw_pending = 0;
    offer(2'b00, 5'd0, 0, 5'd0, 0, 5'd7, 1, 64'h4);
    #1;
    n_tests++; if (ex_valid !== 1'b1 || enablewrite !== 1'b1 || registerunit !== 2'b10 || id_ready !== 1'b1) begin n_fail++; $display("FAIL waw_clear got ev=%b ew=%b ru=%b rdy=%b exp 1 1 10 1", ex_valid, enablewrite, registerunit, id_ready); end
    tick();
    id_valid = 0; waw_pending = 1; waw_row = 5'b00001;
    #1;
    n_tests++; if (ex_valid !== 1'b1 || registerunit !== 2'b00 || writeaddr !== 5'd7) begin n_fail++; $display("FAIL waw_am got ev=%b ru=%b wa=%0d exp 1 00 7", ex_valid, registerunit, writeaddr); end
    tick();
    waw_pending = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    offer(2'b01, 5'd0, 0, 5'd0, 0, 5'd9, 1, 64'hAAAA);
    sb_haz_column = 32'h0000_0100;
    tick();
    id_valid = 0;
    #1;
    n_tests++; if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin n_fail++; $display("FAIL struct_stall got ev=%b rdy=%b exp 0 0", ex_valid, id_ready); end
    sb_haz_column = 0;
    offer(2'b00, 5'd0, 0, 5'd0, 0, 5'd11, 1, 64'hBBBB);
    #1;
    n_tests++; if (ex_valid !== 1'b1 || id_ready !== 1'b1 || enablewrite !== 1'b1 || writeaddr !== 5'd9) begin n_fail++; $display("FAIL b2b_fire got ev=%b rdy=%b ew=%b wa=%0d exp 1 1 1 9", ex_valid, id_ready, enablewrite, writeaddr); end
    tick();
    id_valid = 0;
    #1;
    n_tests++; if (ex_valid !== 1'b1 || writeaddr !== 5'd11 || ex_payload !== 64'hBBBB) begin n_fail++; $display("FAIL b2b_second got ev=%b wa=%0d pl=%h exp 1 11 bbbb", ex_valid, writeaddr, ex_payload); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    offer(2'b00, 5'd0, 0, 5'd0, 0, 5'd4, 1, 64'h5);
    tick();
    flush = 1;
    offer(2'b00, 5'd0, 0, 5'd0, 0, 5'd12, 1, 64'h6);
    #1;
    n_tests++; if (ex_valid !== 1'b0 || enablewrite !== 1'b0 || id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_cycle got ev=%b ew=%b rdy=%b exp 0 0 0", ex_valid, enablewrite, id_ready); end
    tick();
    flush = 0; id_valid = 0; ex_ready = 0;
    #1;
    n_tests++; if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_empty got ev=%b rdy=%b exp 0 1", ex_valid, id_ready); end
    ex_ready = 1;
  endtask

  task automatic test_ready_stall_and_reset();
    do_reset();
    ex_ready = 0;
    offer(2'b00, 5'd0, 0, 5'd0, 0, 5'd6, 1, 64'h7);
    tick();
    id_valid = 0;
    tick();
    n_tests++; if (ex_valid !== 1'b1 || enablewrite !== 1'b0 || stall_count !== 4'd0 || id_ready !== 1'b0) begin n_fail++; $display("FAIL ready_stall got ev=%b ew=%b cnt=%0d rdy=%b exp 1 0 0 0", ex_valid, enablewrite, stall_count, id_ready); end
    ex_ready = 1; reset = 1;
    #1;
    n_tests++; if (ex_valid !== 1'b0 || enablewrite !== 1'b0) begin n_fail++; $display("FAIL midheld_reset got ev=%b ew=%b exp 0 0", ex_valid, enablewrite); end
    reset = 0;
    #1;
    n_tests++; if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset got ev=%b rdy=%b exp 0 1", ex_valid, id_ready); end
  endtask

  task automatic test_saturate();
    do_reset();
    offer(2'b11, 5'd0, 0, 5'd0, 0, 5'd1, 0, 64'h8);
    tick();
    id_valid = 0;
    for (int i = 0; i < 5; i++) tick();
    n_tests++; if (stall_count !== 4'd5 || ex_valid !== 1'b0) begin n_fail++; $display("FAIL illegal_mid got cnt=%0d ev=%b exp 5 0", stall_count, ex_valid); end
    for (int i = 5; i < (1 << SCW) + 3; i++) tick();
    n_tests++; if (stall_count !== 4'hF) begin n_fail++; $display("FAIL saturate got %0d exp 15", stall_count); end
    n_tests++; if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin n_fail++; $display("FAIL illegal_hold got ev=%b rdy=%b exp 0 0", ex_valid, id_ready); end
    flush = 1;
    tick();
    flush = 0;
    #1;
    n_tests++; if (id_ready !== 1'b1 || stall_count !== 4'hF) begin n_fail++; $display("FAIL illegal_flush got rdy=%b cnt=%0d exp 1 15", id_ready, stall_count); end
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_raw();
    test_waw();
    test_back_to_back();
    test_flush();
    test_ready_stall_and_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
